// File: rtl/freq_div_sched.sv
// -----------------------------------------------------------------------------
// freq_div_sched
//
// Scheduler for a programmable integer clock divider shared by two requesters.
// Each requester hands over a divide ratio N on a valid/ready handshake.
// Requesters are arbitrated round-robin. A new ratio only takes effect on a
// period boundary, so the divided waveform never shows a runt or stretched
// pulse. The output is a single-clock, clock-enable style waveform plus a
// one-cycle tick at the start of every period.
//
// Optional build macro: FREQ_DIV_SCHED_STATS_EN
//   When defined, a 16-bit saturating period counter output (period_cnt) is
//   added. It counts ticks and restarts whenever the ratio in force changes.
//
// Ports
//   clk_in      in   sole clock, rising edge
//   rst_n       in   synchronous active-low reset
//   enable      in   1 = run / keep running, 0 = stop at end of current period
//   req0_valid  in   requester 0 offers a ratio
//   req0_n      in   requester 0 ratio (CNT_W)
//   req0_ready  out  requester 0 may hand over this cycle
//   req1_valid  in   requester 1 offers a ratio
//   req1_n      in   requester 1 ratio (CNT_W)
//   req1_ready  out  requester 1 may hand over this cycle
//   div_out     out  divided waveform, registered
//   tick        out  one-cycle pulse on the first cycle of each period
//   cur_n       out  ratio currently in force (CNT_W)
//   busy        out  a ratio change is waiting for the period boundary
//   err         out  one-cycle pulse after an accepted ratio below MIN_N
//   period_cnt  out  (stats build only) ticks since the last ratio change
//   grant_id    out  id of the most recently accepted requester
// -----------------------------------------------------------------------------
module freq_div_sched #(
    parameter int CNT_W     = 10,
    parameter int DEFAULT_N = 7,
    parameter int MIN_N     = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             req0_valid,
    input  logic [CNT_W-1:0] req0_n,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [CNT_W-1:0] req1_n,
    output logic             req1_ready,
    output logic             div_out,
    output logic             tick,
    output logic [CNT_W-1:0] cur_n,
    output logic             busy,
    output logic             err,
`ifdef FREQ_DIV_SCHED_STATS_EN
    output logic [15:0]      period_cnt,
`endif
    output logic             grant_id
);

    localparam logic [CNT_W-1:0] DEFAULT_V = CNT_W'(DEFAULT_N);
    localparam logic [CNT_W-1:0] MIN_V     = CNT_W'(MIN_N);
    localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_n_q, cur_n_d;
    logic [CNT_W-1:0] pend_n_q, pend_n_d;
    logic             grant_id_q, grant_id_d;
    logic             err_q, err_d;
    logic             div_out_q, div_out_d;
    logic             tick_q, tick_d;

    logic             sel_id;
    logic             can_accept;
    logic             xfer;
    logic             xfer_legal;
    logic [CNT_W-1:0] xfer_n;
    logic             cnt_last;

    // ------------------------------------------------------------------
    // Arbitration. On a tie the requester that did not win last time is
    // chosen; with no requester valid the pointer still favours the
    // other side, so an idle requester may see ready=1.
    // ------------------------------------------------------------------
    always_comb begin
        sel_id = ~grant_id_q;
        if (req0_valid && req1_valid) begin
            sel_id = ~grant_id_q;
        end else if (req1_valid) begin
            sel_id = 1'b1;
        end else if (req0_valid) begin
            sel_id = 1'b0;
        end
    end

    assign can_accept = (state_q != ST_PEND);
    assign req0_ready = can_accept && !sel_id;
    assign req1_ready = can_accept && sel_id;

    assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign xfer_n     = sel_id ? req1_n : req0_n;
    assign xfer_legal = xfer && (xfer_n >= MIN_V);

    assign cnt_last   = (cnt_q == (cur_n_q - ONE_V));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_n_d    = cur_n_q;
        pend_n_d   = pend_n_q;
        grant_id_d = xfer ? sel_id : grant_id_q;
        err_d      = xfer && !xfer_legal;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Nothing is being generated, so a new ratio can apply at once.
                if (xfer_legal) begin
                    cur_n_d = xfer_n;
                end
                if (enable) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                cnt_d = cnt_last ? '0 : cnt_q + ONE_V;
                if (cnt_last && !enable) begin
                    state_d = ST_IDLE;
                    // Stopping at this boundary: the new ratio applies now,
                    // the next period will start from IDLE with it.
                    if (xfer_legal) begin
                        cur_n_d = xfer_n;
                    end
                end else if (xfer_legal) begin
                    // Even on the boundary cycle the ratio is parked, so the
                    // period that is just starting runs with the old ratio.
                    pend_n_d = xfer_n;
                    state_d  = ST_PEND;
                end
            end

            ST_PEND: begin
                cnt_d = cnt_last ? '0 : cnt_q + ONE_V;
                if (cnt_last) begin
                    cur_n_d = pend_n_q;
                    state_d = enable ? ST_RUN : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are computed from next state so they line up with the
        // registered counter in the cycle they describe.
        div_out_d = (state_d != ST_IDLE) && (cnt_d < (cur_n_d >> 1));
        tick_d    = (state_d != ST_IDLE) && (cnt_d == '0);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_n_q    <= DEFAULT_V;
            pend_n_q   <= '0;
            grant_id_q <= 1'b1;
            err_q      <= 1'b0;
            div_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_n_q    <= cur_n_d;
            pend_n_q   <= pend_n_d;
            grant_id_q <= grant_id_d;
            err_q      <= err_d;
            div_out_q  <= div_out_d;
            tick_q     <= tick_d;
        end
    end

`ifdef FREQ_DIV_SCHED_STATS_EN
    logic [15:0] period_cnt_q, period_cnt_d;

    // A ratio change restarts the count; if the change coincides with the
    // first tick of the new period, that tick already counts as 1.
    always_comb begin
        period_cnt_d = period_cnt_q;
        if (cur_n_d != cur_n_q) begin
            period_cnt_d = tick_d ? 16'd1 : 16'd0;
        end else if (tick_d && (period_cnt_q != 16'hFFFF)) begin
            period_cnt_d = period_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

    assign div_out  = div_out_q;
    assign tick     = tick_q;
    assign cur_n    = cur_n_q;
    assign busy     = (state_q == ST_PEND);
    assign err      = err_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_freq_div_sched.sv
// -----------------------------------------------------------------------------
// tb_freq_div_sched
//
// Directed bench for freq_div_sched with hand-computed expectations. Inputs
// change 1 ns after a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_freq_div_sched;

    localparam int CNT_W = 10;

    logic             clk_in;
    logic             rst_n;
    logic             enable;
    logic             req0_valid;
    logic [CNT_W-1:0] req0_n;
    logic             req0_ready;
    logic             req1_valid;
    logic [CNT_W-1:0] req1_n;
    logic             req1_ready;
    logic             div_out;
    logic             tick;
    logic [CNT_W-1:0] cur_n;
    logic             busy;
    logic             err;
    logic             grant_id;
`ifdef FREQ_DIV_SCHED_STATS_EN
    logic [15:0]      period_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    freq_div_sched #(
        .CNT_W     (CNT_W),
        .DEFAULT_N (7),
        .MIN_N     (2)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .enable     (enable),
        .req0_valid (req0_valid),
        .req0_n     (req0_n),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_n     (req1_n),
        .req1_ready (req1_ready),
        .div_out    (div_out),
        .tick       (tick),
        .cur_n      (cur_n),
        .busy       (busy),
        .err        (err),
`ifdef FREQ_DIV_SCHED_STATS_EN
        .period_cnt (period_cnt),
`endif
        .grant_id   (grant_id)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // One-cycle handover from a single requester; ready must already be up.
    task automatic send(input int id, input logic [CNT_W-1:0] n);
        string tag;
        if (id == 0) begin
            req0_valid = 1'b1;
            req0_n     = n;
        end else begin
            req1_valid = 1'b1;
            req1_n     = n;
        end
        #1;
        tag = (id == 0) ? "send_ready0" : "send_ready1";
        check(tag, (id == 0) ? req0_ready : req1_ready, 1);
        $display("txn req%0d n=%0d cur_n=%0d", id, n, cur_n);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        req0_valid = 1'b0;
        req0_n     = '0;
        req1_valid = 1'b0;
        req1_n     = '0;
        repeat (3) step();
        rst_n = 1'b1;

        // ---- reset state ----
        check("rst_cur_n", cur_n, 7);
        check("rst_div", div_out, 0);
        check("rst_tick", tick, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_grant", grant_id, 1);
        check("rst_ready0", req0_ready, 1);
        check("rst_ready1", req1_ready, 0);
`ifdef FREQ_DIV_SCHED_STATS_EN
        check("rst_pcnt", period_cnt, 0);
`endif

        // ---- free run at N=7: tick every 7, 3 high / 4 low ----
        enable = 1'b1;
        step();
        for (int k = 0; k < 14; k++) begin
            check("n7_tick", tick, ((k % 7) == 0) ? 1 : 0);
            check("n7_div", div_out, ((k % 7) < 3) ? 1 : 0);
            check("n7_cur", cur_n, 7);
            step();
        end

        // ---- change to N=4 mid-period: pending for phases 2..6 ----
        step();                              // phase 1
        send(0, 4);                          // now phase 2, pending
        for (int k = 2; k < 7; k++) begin
            check("pend_busy", busy, 1);
            check("pend_tick", tick, 0);
            check("pend_cur", cur_n, 7);
            check("pend_div", div_out, (k < 3) ? 1 : 0);
            check("pend_rdy0", req0_ready, 0);
            check("pend_rdy1", req1_ready, 0);
            step();
        end
        for (int k = 0; k < 8; k++) begin
            check("n4_tick", tick, ((k % 4) == 0) ? 1 : 0);
            check("n4_div", div_out, ((k % 4) < 2) ? 1 : 0);
            check("n4_busy", busy, 0);
            check("n4_cur", cur_n, 4);
            step();
        end

        // ---- illegal ratio while running ----
        send(1, 1);                          // phase 1
        check("ill_err", err, 1);
        check("ill_cur", cur_n, 4);
        check("ill_busy", busy, 0);
        check("ill_grant", grant_id, 1);
        step();                              // phase 2
        check("ill_err_clr", err, 0);
        check("ill_busy2", busy, 0);

        // ---- reset while running, then tie after reset ----
        rst_n  = 1'b0;
        enable = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst2_cur", cur_n, 7);
        check("rst2_div", div_out, 0);
        check("rst2_grant", grant_id, 1);
        req0_valid = 1'b1; req0_n = 10'd5;
        req1_valid = 1'b1; req1_n = 10'd9;
        #1;
        check("tie_rdy0", req0_ready, 1);
        check("tie_rdy1", req1_ready, 0);
        $display("txn req0 n=5 (tie)");
        step();
        check("tie_cur5", cur_n, 5);
        check("tie_grant0", grant_id, 0);
        check("tie2_rdy0", req0_ready, 0);
        check("tie2_rdy1", req1_ready, 1);
        req0_valid = 1'b0;
        $display("txn req1 n=9 (tie)");
        step();
        req1_valid = 1'b0;
        check("tie_cur9", cur_n, 9);
        check("tie_grant1", grant_id, 1);

        // ---- width boundaries: N=0 illegal, N=1023 legal ----
        send(0, 10'd0);
        check("n0_err", err, 1);
        check("n0_cur", cur_n, 9);
        send(1, 10'd1023);
        check("nmax_cur", cur_n, 1023);
        check("nmax_err", err, 0);
        enable = 1'b1;
        step();                              // phase 0
        check("nmax_tick0", tick, 1);
        check("nmax_div0", div_out, 1);
        for (int k = 1; k < 1023; k++) begin
            step();
            if (k == 510) check("nmax_div510", div_out, 1);
            if (k == 511) check("nmax_div511", div_out, 0);
            if (k == 1022) check("nmax_tick1022", tick, 0);
        end
        step();
        check("nmax_wrap_tick", tick, 1);

        // ---- minimum ratio N=2 ----
        rst_n  = 1'b0;
        enable = 1'b0;
        step();
        rst_n = 1'b1;
        send(0, 10'd2);
        check("n2_cur", cur_n, 2);
        enable = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            check("n2_tick", tick, ((k % 2) == 0) ? 1 : 0);
            check("n2_div", div_out, ((k % 2) == 0) ? 1 : 0);
            step();
        end
        enable = 1'b0;                       // phase 0
        step();                              // phase 1
        check("n2_stop_tick1", tick, 0);
        step();                              // idle
        check("n2_idle_tick", tick, 0);
        check("n2_idle_div", div_out, 0);
        step();
        check("n2_idle_tick2", tick, 0);

        // ---- stop at N=7 from phase 1 ----
        send(1, 10'd7);
        check("n7b_cur", cur_n, 7);
        enable = 1'b1;
        step();                              // phase 0
        step();                              // phase 1
        enable = 1'b0;
        for (int k = 2; k < 7; k++) begin
            step();
            check("stop_tick", tick, 0);
            check("stop_div", div_out, (k < 3) ? 1 : 0);
        end
        step();
        check("stop_idle_div", div_out, 0);
        check("stop_idle_tick", tick, 0);
        step();
        check("stop_idle_tick2", tick, 0);

        // ---- stop cancelled before the boundary ----
        enable = 1'b1;
        step();                              // phase 0
        check("cancel_tick0", tick, 1);
        step();                              // phase 1
        enable = 1'b0;
        repeat (3) step();                   // phase 4
        enable = 1'b1;
        repeat (2) step();                   // phase 6
        check("cancel_div6", div_out, 0);
        step();                              // phase 0
        check("cancel_tick", tick, 1);
        check("cancel_div", div_out, 1);

        // ---- transfer on the boundary cycle goes through pending ----
        repeat (6) step();                   // phase 6
        send(0, 10'd3);                      // phase 0, pending
        check("bnd_tick", tick, 1);
        check("bnd_busy", busy, 1);
        check("bnd_cur", cur_n, 7);
        repeat (7) step();
        check("bnd_new_cur", cur_n, 3);
        check("bnd_new_tick", tick, 1);
        check("bnd_new_busy", busy, 0);
`ifdef FREQ_DIV_SCHED_STATS_EN
        check("bnd_pcnt", period_cnt, 1);
`endif

        // ---- enable falls together with a transfer ----
        enable = 1'b0;
        send(1, 10'd6);                      // phase 1, pending
        check("fall_busy", busy, 1);
        step();                              // phase 2
        step();                              // boundary -> idle
        check("fall_cur", cur_n, 6);
        check("fall_busy2", busy, 0);
        check("fall_tick", tick, 0);
        check("fall_div", div_out, 0);
        check("fall_grant", grant_id, 1);

        // ---- reset during pending ----
        enable = 1'b1;
        step();                              // phase 0, N=6
        send(0, 10'd2);                      // phase 1, pending
        check("rstp_busy", busy, 1);
        rst_n  = 1'b0;
        enable = 1'b0;
        step();
        check("rstp_cur", cur_n, 7);
        check("rstp_busy2", busy, 0);
        check("rstp_tick", tick, 0);
        check("rstp_div", div_out, 0);
        check("rstp_grant", grant_id, 1);
`ifdef FREQ_DIV_SCHED_STATS_EN
        check("rstp_pcnt", period_cnt, 0);
`endif
        rst_n = 1'b1;
        step();
        check("rstp_cur_after", cur_n, 7);
        check("rstp_busy_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/freq_div_sched.md
Name: freq_div_sched

Overview:
- Controller/scheduler for the team's programmable integer clock divider.
- Two requesters (e.g. host register port, auto-scaling logic) share one divider. Each submits a divide ratio N over a valid/ready handshake.
- The block arbitrates round-robin and applies a new N only on a period boundary, so no runt or stretched pulse ever appears.
- Outputs a single-clock divided waveform (clock-enable style) plus a period tick for downstream logic.

Parameters:
- CNT_W, 10, width of ratio and period counter.
- DEFAULT_N, 7, ratio loaded at reset.
- MIN_N, 2, smallest legal ratio. Requests with N < MIN_N are rejected.

Ports:
- clk_in  input  1  sole clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- enable  input  1  run request. 1 = start/keep dividing; 0 = stop at end of current period.
- req0_valid  input  1  requester 0 has a ratio.
- req0_n  input  CNT_W  requester 0 ratio.
- req0_ready  output  1  requester 0 may hand over.
- req1_valid  input  1  requester 1 has a ratio.
- req1_n  input  CNT_W  requester 1 ratio.
- req1_ready  output  1  requester 1 may hand over.
- div_out  output  1  divided waveform, registered.
- tick  output  1  one-cycle pulse on first cycle of each period.
- cur_n  output  CNT_W  ratio currently in force.
- busy  output  1  a ratio change is pending.
- err  output  1  one-cycle pulse: accepted request had N < MIN_N.
- grant_id  output  1  id of the last accepted requester.

Behaviour:
- Reset (rst_n=0 at a clk_in edge) values:
  - state=IDLE, cnt=0, cur_n=DEFAULT_N, pend_n=0.
  - div_out=0, tick=0, busy=0, err=0, grant_id=1, so req0 wins the first tie.
  - Reset mid-operation aborts everything, including pending changes, with no completion.
- FSM states: IDLE, RUN, PEND.
  - IDLE: cnt held 0, div_out=0, tick=0. When enable=1, go to RUN next cycle; that cycle has cnt=0 and tick=1.
  - RUN: cnt counts 0..cur_n-1, then wraps to 0. On an accepted legal request, latch pend_n and go to PEND.
  - PEND: counts like RUN, with busy=1. At cnt==cur_n-1, next cycle has cur_n=pend_n, cnt=0, tick=1, and state returns to RUN (or IDLE if enable=0).
  - Stop: when enable=0 in RUN or PEND, the block finishes the current period. At cnt==cur_n-1 it goes to IDLE.
  - enable returning to 1 before the boundary cancels the stop. No glitch occurs.
- Waveform: div_out=1 while cnt < (cur_n>>1), else 0.
  - Example N=7: 3 high, 4 low. Example N=8: 4 high, 4 low.
  - tick=1 when cnt==0 in RUN/PEND.
- Handshake:
  - reqX_ready=1 in IDLE and RUN when arbitration selects X. Both ready=0 in PEND.
  - Transfer happens on valid&&ready in the same cycle.
  - ready does not depend combinationally on that requester's own valid beyond arbitration. An idle requester's ready may be 1.
- Arbitration: if both valid, grant the requester other than grant_id. If only one is valid, grant it. grant_id updates on every transfer.
- Ratio application:
  - In IDLE, an accepted legal N updates cur_n on the next cycle with no PEND.
  - Illegal N (< MIN_N) is consumed: err pulses 1 cycle after the transfer, and cur_n/state are unchanged.
- Simultaneous events:
  - Transfer in the same cycle as the boundary (cnt==cur_n-1) in RUN: the new N goes through PEND and is applied at the next boundary, never mid-period.
  - enable falling together with a transfer: the change is still applied at the boundary, then the block goes to IDLE.
- Width: cnt is CNT_W bits and compares against cur_n-1. N = 2^CNT_W-1 is legal. N=0 and N=1 are illegal at default MIN_N.

Optional Feature:
- Macro: FREQ_DIV_SCHED_STATS_EN.
- Defined: adds output period_cnt, 16 bits.
  - Increments on every tick.
  - Saturates at 0xFFFF.
  - Clears on reset and whenever cur_n changes (counted from the tick of the new period, which reads 1).
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan:
- Reset then enable=1, no requests -> tick every 7 cycles; div_out 3 high/4 low; cur_n=7.
- RUN at N=7, req0 N=4 accepted at cnt=2 -> busy=1 for 5 cycles; old period completes (7 cycles); next period 4 cycles (2 high/2 low); tick at each start.
- Both valid on same cycle after reset (req0 N=5, req1 N=9) -> req0 granted first, then req1 after req0 change applies; cur_n sequence 7->5->9; grant_id 0 then 1.
- req1 N=1 in RUN -> transfer completes; err=1 one cycle; cur_n stays 7; no PEND.
- enable dropped at cnt=1 (N=7) -> 5 more cycles of counting, then IDLE, div_out=0; raise enable at cnt=4 in a repeat run -> no stop, continuous ticks.
- rst_n=0 during PEND -> next cycle IDLE, cur_n=DEFAULT_N, busy=0; with FREQ_DIV_SCHED_STATS_EN, period_cnt=0.
